// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared declarations for the UART receive path.
//   rx_state_t  : receiver state encoding (IDLE, START, DATA, PARITY, STOP, BREAK)
//   OVERSAMPLE  : oversample ticks per bit
//   MID_SAMPLE  : tick within the start bit at which it is validated
//   even_parity : even-parity bit for a data byte
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler_if
// Byte handshake between the receiver (master, byte source) and its consumer
// (slave).
//   rx_data  : received byte, stable while rx_valid is high
//   rx_valid : holding register full
//   rx_ready : consumer accepts; transfer when rx_valid & rx_ready
// -----------------------------------------------------------------------------
interface uart_rx_sampler_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running oversample tick generator, shared by receiver and transmitter.
// Counts 0..DIV-1 and asserts tick while the count is DIV-1. DIV must be >= 2.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   align   : forces the count to 0 on the next edge (phase alignment)
//   tick    : one-cycle oversample strobe
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic align,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (align || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// 16x oversampled UART receiver: two-flop synchroniser, mid-bit sampling,
// false-start rejection, stop-bit check, one-byte holding register with
// sticky overrun.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data
// bits plus a parity_err output). Undefined gives 8N1.
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   bus        : byte handshake (rx_data / rx_valid / rx_ready), master side
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : sticky, a completed byte was dropped; cleared by a handshake
//   busy       : high in every state except IDLE
//   parity_err : (UART_RX_PARITY_EN only) one-cycle pulse in the deliver
//                cycle when the parity bit is wrong
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DIV    = (CLK_HZ + 8 * BAUD) / (16 * BAUD)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rx,
  uart_rx_sampler_if.master  bus,
  output logic               frame_err,
  output logic               overrun,
  output logic               busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);

  // Synchroniser
  logic sync1_q, rxs_q;
  logic rxs;

  // Receiver FSM and datapath
  rx_state_t  state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;

  // Holding register and flags
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  logic tick;
  logic align;
  logic stop_ok;
  logic stop_bad;
  logic hs;
  logic load;
  logic drop;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic parity_err_q, parity_err_d;
`endif

  assign rxs = rxs_q;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .align   (align),
    .tick    (tick)
  );

  // ---------------------------------------------------------------------------
  // Frame state machine. scnt counts ticks within the current bit; its 4-bit
  // wrap from 15 to 0 restarts the count for the next bit automatically.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    align     = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          scnt_d  = '0;
          align   = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          if (scnt_q == MID_TICK) begin
            scnt_d = '0;
            // Line back high at mid start bit: glitch, not a frame.
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_idx_d = '0;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == LAST_TICK) begin
            shreg_d   = {rxs, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == LAST_TICK) begin
            par_bit_d = rxs;
            state_d   = STOP;
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == LAST_TICK) begin
            if (rxs) begin
              stop_ok = 1'b1;
              state_d = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = BREAK;
            end
          end
        end
      end

      // Hold off until the line returns high so a long low level (break)
      // cannot start a new frame.
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Holding register. A handshake in the same cycle as a delivery frees the
  // slot, so an always-ready consumer never sees overrun.
  // ---------------------------------------------------------------------------
  always_comb begin
    hs   = rx_valid_q & bus.rx_ready;
    load = stop_ok & (~rx_valid_q | hs);
    drop = stop_ok & rx_valid_q & ~hs;

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;

    if (hs) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (load) begin
      rx_data_d  = shreg_q;
      rx_valid_d = 1'b1;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end

    frame_err_d = stop_bad;
`ifdef UART_RX_PARITY_EN
    parity_err_d = stop_ok & (even_parity(shreg_q) != par_bit_q);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= IDLE;
      scnt_q      <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx;
      rxs_q       <= sync1_q;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Directed + randomized bench for uart_rx_sampler at DIV=4 (64 clk per bit).
// Frames are driven bit by bit; a transaction-level model of the holding
// register predicts the stream of bytes the consumer should accept.
// Honours UART_RX_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

  localparam int unsigned BAUD    = 115200;
  localparam int unsigned CLK_HZ  = 16 * 4 * BAUD;
  localparam int          DIV     = 4;
  localparam int          BIT_CLK = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Cycles from the rx fall (driven just after an edge) to the cycle in which
  // the stop bit is sampled: 2 synchroniser clocks, then the stop tick.
  localparam int STOP_CYC = 2 + (8 + 16 * (9 + PAR_BITS)) * DIV;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic rx      = 1'b1;
  logic frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx_sampler_if bus ();

  uart_rx_sampler #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .bus        (bus),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed traffic, sampled on the falling edge.
  logic [7:0] got_q[$];
  int valid_cyc = 0;
  int fe_cnt    = 0;
  int pe_cnt    = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.rx_valid && bus.rx_ready) begin
        got_q.push_back(bus.rx_data);
        $display("[TB] t=%0t accepted byte 0x%02h", $time, bus.rx_data);
      end
      if (bus.rx_valid) valid_cyc <= valid_cyc + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
    end
  end

  // Transaction-level model of the one-byte holding register.
  logic [7:0] exp_q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovr   = 1'b0;

  task automatic model_handshake();
    if (m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // A good frame completes; 'ready' is the consumer's state in that cycle.
  task automatic model_deliver(input logic [7:0] b, input logic ready);
    if (!m_valid || ready) begin
      if (m_valid) model_handshake();
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, "_byte"}, got_q[i], exp_q[i]);
    end
  endtask

  // Drive rx to v for n clocks; always entered and left 1 time unit after an edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(b[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    hold(par, BIT_CLK);
`else
    if (par === 1'bx) $display("[TB] unexpected parity argument");
`endif
    hold(stop, BIT_CLK);
  endtask

  task automatic send_good(input logic [7:0] b);
    $display("[TB] t=%0t send byte 0x%02h", $time, b);
    send_frame(b, 1'b1, ^b);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    int v0;
    int f0;
    int p0;

    bus.rx_ready = 1'b1;
    reset_n      = 1'b0;
    rx           = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // ---- reset state
    check("rst_data",  bus.rx_data,  8'h00);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_ferr",  frame_err,    1'b0);
    check("rst_ovr",   overrun,      1'b0);
    check("rst_busy",  busy,         1'b0);
    reset_n = 1'b1;
    hold(1'b1, 10);

    // ---- basic receive, back-to-back, consumer always ready
    v0 = valid_cyc; f0 = fe_cnt; p0 = pe_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      b = 8'h55;
      else if (i == 1) b = 8'hA3;
      else             b = 8'($urandom_range(0, 255));
      send_good(b);
      model_deliver(b, 1'b1);
      model_handshake();
    end
    hold(1'b1, 16);
    check_stream("basic");
    check("basic_valid_cycles", valid_cyc - v0, 6);
    check("basic_ferr", fe_cnt - f0, 0);
    check("basic_perr", pe_cnt - p0, 0);
    check("basic_ovr", overrun, 1'b0);
    check("basic_busy", busy, 1'b0);

    // ---- overrun
    bus.rx_ready = 1'b0;
    send_good(8'h31); model_deliver(8'h31, 1'b0);
    send_good(8'h32); model_deliver(8'h32, 1'b0);
    hold(1'b1, 16);
    check("ovr_valid", bus.rx_valid, m_valid);
    check("ovr_data",  bus.rx_data,  m_data);
    check("ovr_flag",  overrun,      m_ovr);
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    model_handshake();
    check("ovr_clr_valid", bus.rx_valid, m_valid);
    check("ovr_clr_flag",  overrun,      m_ovr);
    check_stream("ovr");

    // ---- false start
    bus.rx_ready = 1'b1;
    v0 = valid_cyc; f0 = fe_cnt;
    hold(1'b0, 20);
    hold(1'b1, 3 * BIT_CLK);
    check("fs_busy", busy, 1'b0);
    check("fs_valid_cycles", valid_cyc - v0, 0);
    check("fs_ferr", fe_cnt - f0, 0);
    send_good(8'h7E); model_deliver(8'h7E, 1'b1); model_handshake();
    hold(1'b1, 16);
    check_stream("fs_next");

    // ---- framing error with held-low line
    v0 = valid_cyc; f0 = fe_cnt;
    $display("[TB] t=%0t send byte 0x41 with stop=0", $time);
    send_frame(8'h41, 1'b0, ^8'h41);
    hold(1'b0, 3 * BIT_CLK);
    check("fe_pulse", fe_cnt - f0, 1);
    check("fe_no_valid", valid_cyc - v0, 0);
    check("fe_busy_low", busy, 1'b1);
    hold(1'b1, 8);
    check("fe_busy_rel", busy, 1'b0);
    send_good(8'h42); model_deliver(8'h42, 1'b1); model_handshake();
    hold(1'b1, 16);
    check_stream("fe_next");

    // ---- simultaneous accept and load
    bus.rx_ready = 1'b0;
    a_byte = 8'($urandom_range(0, 255));
    b_byte = 8'($urandom_range(1, 255));
    send_good(a_byte); model_deliver(a_byte, 1'b0);
    hold(1'b1, 16);
    fork
      send_good(b_byte);
      begin
        repeat (STOP_CYC) @(posedge clk);
        #1;
        check("sim_pre_data", bus.rx_data, a_byte);
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sim_valid", bus.rx_valid, 1'b1);
        check("sim_data",  bus.rx_data,  b_byte);
        check("sim_ovr",   overrun,      1'b0);
      end
    join
    model_deliver(b_byte, 1'b1);
    model_handshake();
    hold(1'b1, 16);
    check_stream("sim");

    // ---- reset mid-frame (during bit 4)
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT_CLK);
    hold(1'b0, BIT_CLK / 2);
    reset_n = 1'b0;
    hold(1'b0, 4);
    check("mid_rst_data",  bus.rx_data,  8'h00);
    check("mid_rst_valid", bus.rx_valid, 1'b0);
    check("mid_rst_ferr",  frame_err,    1'b0);
    check("mid_rst_ovr",   overrun,      1'b0);
    check("mid_rst_busy",  busy,         1'b0);
    rx = 1'b1;
    hold(1'b1, 4);
    reset_n = 1'b1;
    hold(1'b1, 2 * BIT_CLK);
    check("post_rst_busy",  busy,         1'b0);
    check("post_rst_valid", bus.rx_valid, 1'b0);
    p0 = pe_cnt; v0 = valid_cyc;
`ifdef UART_RX_PARITY_EN
    $display("[TB] t=%0t send byte 0x07 with parity=0", $time);
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_err_pulse", pe_cnt - p0, 1);
`else
    send_good(8'h07);
    check("par_err_pulse", pe_cnt - p0, 0);
`endif
    model_deliver(8'h07, 1'b1); model_handshake();
    hold(1'b1, 16);
    check("post_rst_data", bus.rx_data, 8'h07);
    check("post_rst_valid_cycles", valid_cyc - v0, 1);
    check_stream("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
